// File: rtl/mux_scan_ctrl.sv
// Scan sequencer for the 4:1 channel mux: switch, settle, then one capture handshake per enabled channel.
// Optional build macro MUX_SCAN_CAL_SLOT_EN appends a calibration slot (MUX_SEL=3'b100) to every round.
module mux_scan_ctrl #(
  parameter int SETTLE_W = 8,
  parameter int ROUNDS_W = 8
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic [3:0]          CH_MASK,
  input  logic [SETTLE_W-1:0] SETTLE_CYC,
  input  logic [ROUNDS_W-1:0] ROUNDS,
  input  logic                CAP_ACK,
  output logic [2:0]          MUX_SEL,
  output logic                MUX_RST,
  output logic                CAP_REQ,
  output logic [2:0]          CH_ID,
  output logic                ROUND_DONE,
  output logic                BUSY
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_SWITCH  = 2'd1,
    ST_SETTLE  = 2'd2,
    ST_CAPTURE = 2'd3
  } state_t;

  state_t              state_q;
  logic [2:0]          mux_sel_q;
  logic                mux_rst_q;
  logic                cap_req_q;
  logic [2:0]          ch_id_q;
  logic                round_done_q;
  logic                busy_q;
  logic [SETTLE_W-1:0] settle_q;
  logic [ROUNDS_W-1:0] round_cnt_q;
  logic [ROUNDS_W-1:0] rounds_q;
  logic [3:0]          mask_q;
  logic                first_q;

  logic [2:0]          next_ch;
  logic                more_ch;
  logic                last_slot;
  logic [ROUNDS_W-1:0] cnt_inc;
  logic                rounds_met;

  // Lowest enabled channel above the current slot (or the lowest overall on a round's first slot).
  always_comb begin
`ifdef MUX_SCAN_CAL_SLOT_EN
    next_ch = 3'b100;
`else
    next_ch = 3'b000;
`endif
    more_ch = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mask_q[i] && (first_q || (3'(i) > mux_sel_q))) begin
        next_ch = 3'(i);
        more_ch = 1'b1;
      end
    end
  end

`ifdef MUX_SCAN_CAL_SLOT_EN
  assign last_slot = (mux_sel_q == 3'b100);
`else
  assign last_slot = !more_ch;
`endif

  assign cnt_inc    = (round_cnt_q == '1) ? round_cnt_q : round_cnt_q + 1'b1;
  assign rounds_met = (rounds_q != '0) && (cnt_inc == rounds_q);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      mux_sel_q    <= 3'b111;
      mux_rst_q    <= 1'b1;
      cap_req_q    <= 1'b0;
      ch_id_q      <= 3'b000;
      round_done_q <= 1'b0;
      busy_q       <= 1'b0;
      settle_q     <= '0;
      round_cnt_q  <= '0;
      rounds_q     <= '0;
      mask_q       <= '0;
      first_q      <= 1'b0;
    end else begin
      round_done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (EN && (CH_MASK != 4'b0000)) begin
            mask_q      <= CH_MASK;
            rounds_q    <= ROUNDS;
            round_cnt_q <= '0;
            first_q     <= 1'b1;
            busy_q      <= 1'b1;
            state_q     <= ST_SWITCH;
          end
        end
        ST_SWITCH: begin
          if (!EN) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= 3'b111;
            mux_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end else begin
            mux_sel_q <= next_ch;
            mux_rst_q <= 1'b0;
            settle_q  <= SETTLE_CYC;
            first_q   <= 1'b0;
            state_q   <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (!EN) begin
            state_q   <= ST_IDLE;
            mux_sel_q <= 3'b111;
            mux_rst_q <= 1'b1;
            busy_q    <= 1'b0;
          end else if (settle_q <= SETTLE_W'(1)) begin
            // A zero settle still spends one cycle here with the new Sel applied.
            state_q   <= ST_CAPTURE;
            cap_req_q <= 1'b1;
            ch_id_q   <= mux_sel_q;
          end else begin
            settle_q <= settle_q - 1'b1;
          end
        end
        ST_CAPTURE: begin
          if (CAP_ACK) begin
            cap_req_q <= 1'b0;
            if (!last_slot) begin
              if (EN) begin
                state_q <= ST_SWITCH;
              end else begin
                state_q   <= ST_IDLE;
                mux_sel_q <= 3'b111;
                mux_rst_q <= 1'b1;
                busy_q    <= 1'b0;
              end
            end else begin
              round_done_q <= 1'b1;
              round_cnt_q  <= cnt_inc;
              if (!EN || rounds_met || (CH_MASK == 4'b0000)) begin
                state_q   <= ST_IDLE;
                mux_sel_q <= 3'b111;
                mux_rst_q <= 1'b1;
                busy_q    <= 1'b0;
              end else begin
                mask_q  <= CH_MASK;
                first_q <= 1'b1;
                state_q <= ST_SWITCH;
              end
            end
          end
        end
        default: begin
          state_q   <= ST_IDLE;
          mux_sel_q <= 3'b111;
          mux_rst_q <= 1'b1;
          cap_req_q <= 1'b0;
          busy_q    <= 1'b0;
        end
      endcase
    end
  end

  assign MUX_SEL    = mux_sel_q;
  assign MUX_RST    = mux_rst_q;
  assign CAP_REQ    = cap_req_q;
  assign CH_ID      = ch_id_q;
  assign ROUND_DONE = round_done_q;
  assign BUSY       = busy_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Directed bench for mux_scan_ctrl: reset, mask walking, settle latency, round control, EN drop.
// Inputs change and outputs are sampled 1 time unit after each rising clock edge.
module tb_mux_scan_ctrl;

  logic       CLK;
  logic       RST;
  logic       EN;
  logic [3:0] CH_MASK;
  logic [7:0] SETTLE_CYC;
  logic [7:0] ROUNDS;
  logic       CAP_ACK;
  logic [2:0] MUX_SEL;
  logic       MUX_RST;
  logic       CAP_REQ;
  logic [2:0] CH_ID;
  logic       ROUND_DONE;
  logic       BUSY;

  int vectors = 0;
  int misses  = 0;
  logic sel4_seen = 1'b0;

  mux_scan_ctrl #(.SETTLE_W(8), .ROUNDS_W(8)) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .CH_MASK(CH_MASK), .SETTLE_CYC(SETTLE_CYC),
    .ROUNDS(ROUNDS), .CAP_ACK(CAP_ACK), .MUX_SEL(MUX_SEL), .MUX_RST(MUX_RST),
    .CAP_REQ(CAP_REQ), .CH_ID(CH_ID), .ROUND_DONE(ROUND_DONE), .BUSY(BUSY)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(negedge CLK) if (MUX_SEL === 3'b100) sel4_seen <= 1'b1;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      misses++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bounded wait for a capture request, then check its channel id.
  task automatic wait_req(input string tag, input logic [2:0] id);
    int n = 0;
    while (CAP_REQ !== 1'b1 && n < 60) begin tick(); n++; end
    chk({tag, "_req"}, 32'(CAP_REQ), 32'd1);
    chk({tag, "_id"}, 32'(CH_ID), 32'(id));
  endtask

  // Wait for MUX_SEL to reach sel, then count cycles until CAP_REQ rises.
  task automatic sel_to_req(input string tag, input logic [2:0] sel, input int lat);
    int n = 0;
    while (MUX_SEL !== sel && n < 60) begin tick(); n++; end
    chk({tag, "_sel"}, 32'(MUX_SEL), 32'(sel));
    n = 0;
    while (CAP_REQ !== 1'b1 && n < 60) begin tick(); n++; end
    chk({tag, "_lat"}, 32'(n), 32'(lat));
    chk({tag, "_id"}, 32'(CH_ID), 32'(sel));
  endtask

  task automatic do_ack();
    CAP_ACK = 1'b1;
    tick();
    CAP_ACK = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST = 1'b1; EN = 1'b0; CH_MASK = 4'b0000; SETTLE_CYC = 8'd0; ROUNDS = 8'd0; CAP_ACK = 1'b0;
    repeat (3) tick();
    chk("rst_sel", 32'(MUX_SEL), 32'd7);
    chk("rst_mrst", 32'(MUX_RST), 32'd1);
    chk("rst_req", 32'(CAP_REQ), 32'd0);
    chk("rst_chid", 32'(CH_ID), 32'd0);
    chk("rst_rd", 32'(ROUND_DONE), 32'd0);
    chk("rst_busy", 32'(BUSY), 32'd0);
    RST = 1'b0;
    tick();

    // 1: reset mid-capture, late ack ignored
    CH_MASK = 4'b0001; SETTLE_CYC = 8'd0; ROUNDS = 8'd0; EN = 1'b1;
    wait_req("t1", 3'd0);
    chk("t1_mrst_run", 32'(MUX_RST), 32'd0);
    chk("t1_busy_run", 32'(BUSY), 32'd1);
    RST = 1'b1;
    tick();
    chk("t1_req_rst", 32'(CAP_REQ), 32'd0);
    chk("t1_mrst_rst", 32'(MUX_RST), 32'd1);
    chk("t1_sel_rst", 32'(MUX_SEL), 32'd7);
    chk("t1_busy_rst", 32'(BUSY), 32'd0);
    RST = 1'b0; EN = 1'b0; CAP_ACK = 1'b1;
    tick(); tick();
    CAP_ACK = 1'b0;
    chk("t1_late_req", 32'(CAP_REQ), 32'd0);
    chk("t1_late_busy", 32'(BUSY), 32'd0);
    chk("t1_late_rd", 32'(ROUND_DONE), 32'd0);
    tick();

`ifndef MUX_SCAN_CAL_SLOT_EN
    // 2: mask 1010, settle 3, one round
    CH_MASK = 4'b1010; SETTLE_CYC = 8'd3; ROUNDS = 8'd1; EN = 1'b1;
    sel_to_req("t2_s1", 3'd1, 3);
    tick();
    chk("t2_hold", 32'(CAP_REQ), 32'd1);
    do_ack();
    chk("t2_drop", 32'(CAP_REQ), 32'd0);
    chk("t2_rd_mid", 32'(ROUND_DONE), 32'd0);
    sel_to_req("t2_s2", 3'd3, 3);
    tick();
    do_ack();
    EN = 1'b0;
    chk("t2_rd_end", 32'(ROUND_DONE), 32'd1);
    chk("t2_busy_end", 32'(BUSY), 32'd0);
    chk("t2_sel_end", 32'(MUX_SEL), 32'd7);
    chk("t2_mrst_end", 32'(MUX_RST), 32'd1);
    tick();
    chk("t2_rd_pulse", 32'(ROUND_DONE), 32'd0);
    chk("t2_busy_idle", 32'(BUSY), 32'd0);
`endif

    // 3: empty mask never starts
    begin
      logic busy_seen = 1'b0;
      logic mrst_low = 1'b0;
      CH_MASK = 4'b0000; EN = 1'b1;
      for (int i = 0; i < 20; i++) begin
        tick();
        if (BUSY !== 1'b0) busy_seen = 1'b1;
        if (MUX_RST !== 1'b1) mrst_low = 1'b1;
      end
      chk("t3_busy", 32'(busy_seen), 32'd0);
      chk("t3_mrst", 32'(mrst_low), 32'd0);
      EN = 1'b0;
      tick();
    end

`ifndef MUX_SCAN_CAL_SLOT_EN
    // 4: continuous scan, EN dropped during third slot's capture
    CH_MASK = 4'b1111; SETTLE_CYC = 8'd0; ROUNDS = 8'd0; EN = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel_to_req("t4_r1", 3'(i), 1);
      do_ack();
      chk("t4_r1_rd", 32'(ROUND_DONE), (i == 3) ? 32'd1 : 32'd0);
    end
    chk("t4_busy_cont", 32'(BUSY), 32'd1);
    for (int i = 0; i < 2; i++) begin
      sel_to_req("t4_r2", 3'(i), 1);
      do_ack();
    end
    sel_to_req("t4_r2", 3'd2, 1);
    EN = 1'b0;
    tick();
    chk("t4_hold", 32'(CAP_REQ), 32'd1);
    do_ack();
    chk("t4_drop", 32'(CAP_REQ), 32'd0);
    chk("t4_rd", 32'(ROUND_DONE), 32'd0);
    chk("t4_busy", 32'(BUSY), 32'd0);
    chk("t4_mrst", 32'(MUX_RST), 32'd1);
    tick();
    chk("t4_rd2", 32'(ROUND_DONE), 32'd0);

    // 5: mask change mid-round applies from the next round
    CH_MASK = 4'b0001; SETTLE_CYC = 8'd1; ROUNDS = 8'd2; EN = 1'b1;
    sel_to_req("t5_c0", 3'd0, 1);
    CH_MASK = 4'b0110;
    do_ack();
    chk("t5_rd1", 32'(ROUND_DONE), 32'd1);
    chk("t5_busy1", 32'(BUSY), 32'd1);
    sel_to_req("t5_c1", 3'd1, 1);
    do_ack();
    chk("t5_rd_mid", 32'(ROUND_DONE), 32'd0);
    sel_to_req("t5_c2", 3'd2, 1);
    do_ack();
    EN = 1'b0;
    chk("t5_rd2", 32'(ROUND_DONE), 32'd1);
    chk("t5_busy2", 32'(BUSY), 32'd0);
    tick();
`endif

    // 6: single channel, two rounds (plus calibration slot when built in)
    CH_MASK = 4'b0001; SETTLE_CYC = 8'd0; ROUNDS = 8'd2; EN = 1'b1;
`ifdef MUX_SCAN_CAL_SLOT_EN
    for (int r = 0; r < 2; r++) begin
      wait_req("t6_ch", 3'd0);
      do_ack();
      chk("t6_rd_ch", 32'(ROUND_DONE), 32'd0);
      wait_req("t6_cal", 3'd4);
      chk("t6_cal_sel", 32'(MUX_SEL), 32'd4);
      do_ack();
      chk("t6_rd_cal", 32'(ROUND_DONE), 32'd1);
    end
`else
    for (int r = 0; r < 2; r++) begin
      wait_req("t6_ch", 3'd0);
      do_ack();
      chk("t6_rd", 32'(ROUND_DONE), 32'd1);
    end
`endif
    EN = 1'b0;
    chk("t6_busy", 32'(BUSY), 32'd0);
    tick();

`ifndef MUX_SCAN_CAL_SLOT_EN
    chk("no_sel4", 32'(sel4_seen), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, misses);
    $finish;
  end

endmodule
